// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared power-state type, RAM mode encodings and default widths for the RAM port arbiter.
package ram_ctrl_pkg;
  typedef enum logic [1:0] {RUN, SLEEP, WAKE} pwr_state_e;
  localparam logic [1:0] MODE_X32 = 2'b00;
  localparam logic [1:0] MODE_X16 = 2'b01;
  localparam logic [1:0] MODE_X8  = 2'b10;
  localparam logic FMODE_RAM = 1'b0;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/ram_pwr_seq.sv
// ram_pwr_seq: idle/wake counters and RUN/SLEEP/WAKE state machine gating arbiter grants.
module ram_pwr_seq
  import ram_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic any_req,
  output logic grant_allow,
  output logic powerdn,
  output logic sleeping
);
  localparam int IW = $clog2(IDLE_CYCLES + 2);
  localparam int WW = $clog2(WAKE_CYCLES + 2);
  pwr_state_e state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;
  logic pd_q;
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    wake_d  = '0;
    case (state_q)
      RUN: begin
        idle_d = any_req ? '0 : idle_q + 1'b1;
        // a request in the expiring cycle wins over going to sleep
        if (!any_req && IDLE_CYCLES != 0 && int'(idle_q) + 1 == IDLE_CYCLES) state_d = SLEEP;
      end
      SLEEP: state_d = any_req ? WAKE : SLEEP;
      WAKE: begin
        wake_d  = wake_q + 1'b1;
        state_d = (int'(wake_q) + 1 >= WAKE_CYCLES) ? RUN : WAKE;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      idle_q  <= '0;
      wake_q  <= '0;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      pd_q    <= state_d == SLEEP;
    end
  end
  assign grant_allow = state_q == RUN;
  assign powerdn     = pd_q;
  assign sleeping    = pd_q;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one simple RAM between requesters A and B,
// with a registered command stage, read-data routing and power-down sequencing.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic [DATA_W-1:0] B_RDATA,
  output logic [ADDR_W-1:0] RAM_RADDR,
  output logic              RAM_REN,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic              RAM_WEN,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              RAM_POWERDN,
  output logic              SLEEPING,
  output logic [1:0]        RAM_RMODE,
  output logic [1:0]        RAM_WMODE,
  output logic              RAM_FMODE,
  output logic              RAM_FFLUSH,
  output logic              RAM_ENDIAN
);
  logic allow, gnt, sel_we;
  logic prio_q, prio_d, ren_q, ren_d, wen_q, wen_d, rsrc_q, rsrc_d;
  logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [ADDR_W-1:0] sel_addr, raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DATA_W-1:0] sel_wdata, wdata_q, wdata_d;
  ram_pwr_seq #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)) u_pwr (
    .clk(CLK),
    .rst_n(RESET_N),
    .any_req(A_REQ || B_REQ),
    .grant_allow(allow),
    .powerdn(RAM_POWERDN),
    .sleeping(SLEEPING)
  );
  // prio_q = 1 favours B; it flips only when a grant is issued
  always_comb begin
    A_GNT      = allow && A_REQ && (!B_REQ || !prio_q);
    B_GNT      = allow && B_REQ && (!A_REQ || prio_q);
    gnt        = A_GNT || B_GNT;
    sel_we     = B_GNT ? B_WE : A_WE;
    sel_addr   = B_GNT ? B_ADDR : A_ADDR;
    sel_wdata  = B_GNT ? B_WDATA : A_WDATA;
    prio_d     = gnt ? A_GNT : prio_q;
    ren_d      = gnt && !sel_we;
    wen_d      = gnt && sel_we;
    raddr_d    = ren_d ? sel_addr : raddr_q;
    waddr_d    = wen_d ? sel_addr : waddr_q;
    wdata_d    = wen_d ? sel_wdata : wdata_q;
    rsrc_d     = ren_d ? B_GNT : rsrc_q;
    a_rvalid_d = ren_q && !rsrc_q;
    b_rvalid_d = ren_q && rsrc_q;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prio_q     <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rsrc_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rsrc_q     <= rsrc_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end
  assign RAM_REN    = ren_q;
  assign RAM_WEN    = wen_q;
  assign RAM_RADDR  = raddr_q;
  assign RAM_WADDR  = waddr_q;
  assign RAM_WDATA  = wdata_q;
  assign A_RVALID   = a_rvalid_q;
  assign B_RVALID   = b_rvalid_q;
  assign A_RDATA    = RAM_RDATA;
  assign B_RDATA    = RAM_RDATA;
  assign RAM_RMODE  = MODE_X32;
  assign RAM_WMODE  = MODE_X32;
  assign RAM_FMODE  = FMODE_RAM;
  assign RAM_FFLUSH = 1'b0;
  assign RAM_ENDIAN = 1'b0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized requesters against a behavioural arbiter/power model,
// with a queue scoreboard checking RAM commands and read returns.
module tb_ram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {bit who; logic [DW-1:0] data;} rd_t;
  logic CLK = 0;
  logic RESET_N = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic A_GNT, A_RVALID, B_GNT, B_RVALID, RAM_REN, RAM_WEN, RAM_POWERDN, SLEEPING;
  logic RAM_FMODE, RAM_FFLUSH, RAM_ENDIAN;
  logic [1:0] RAM_RMODE, RAM_WMODE;
  logic [DW-1:0] A_RDATA, B_RDATA, RAM_WDATA, RAM_RDATA;
  logic [AW-1:0] RAM_RADDR, RAM_WADDR;
  logic z_agnt, z_arv, z_bgnt, z_brv, z_ren, z_wen, z_pd, z_sl, z_fm, z_ff, z_en;
  logic [1:0] z_rm, z_wm;
  logic [DW-1:0] z_ard, z_brd, z_wd;
  logic [DW-1:0] zero = '0;
  logic [AW-1:0] z_ra, z_wa;
  logic [DW-1:0] ram [2048];
  logic [DW-1:0] mm [2048];
  cmd_t cq[$];
  rd_t rq[$];
  int pass_n = 0, tot_n = 0;
  int fav = 0, m_idle = 0, m_wake = 0;
  bit m_sleep = 0, ga = 0, gb = 0;
  always #5 CLK = ~CLK;
  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .RAM_RADDR(RAM_RADDR), .RAM_REN(RAM_REN), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .RAM_POWERDN(RAM_POWERDN), .SLEEPING(SLEEPING),
    .RAM_RMODE(RAM_RMODE), .RAM_WMODE(RAM_WMODE), .RAM_FMODE(RAM_FMODE),
    .RAM_FFLUSH(RAM_FFLUSH), .RAM_ENDIAN(RAM_ENDIAN)
  );
  // second instance with power-down disabled, fed the same requests
  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IDLE_CYCLES(0), .WAKE_CYCLES(WAKE)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_GNT(z_agnt), .A_RVALID(z_arv), .A_RDATA(z_ard),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_GNT(z_bgnt), .B_RVALID(z_brv), .B_RDATA(z_brd),
    .RAM_RADDR(z_ra), .RAM_REN(z_ren), .RAM_WADDR(z_wa), .RAM_WEN(z_wen),
    .RAM_WDATA(z_wd), .RAM_RDATA(zero), .RAM_POWERDN(z_pd), .SLEEPING(z_sl),
    .RAM_RMODE(z_rm), .RAM_WMODE(z_wm), .RAM_FMODE(z_fm),
    .RAM_FFLUSH(z_ff), .RAM_ENDIAN(z_en)
  );
  always @(posedge CLK) begin
    if (RAM_WEN) ram[RAM_WADDR] <= RAM_WDATA;
    if (RAM_REN) RAM_RDATA <= ram[RAM_RADDR];
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic model_step();
    bit run, any, ea, eb;
    cmd_t c;
    rd_t r;
    run = !m_sleep && m_wake == 0;
    any = a_req || b_req;
    ea = run && a_req && (!b_req || fav == 0);
    eb = run && b_req && !ea;
    chk("a_gnt", A_GNT, ea);
    chk("b_gnt", B_GNT, eb);
    chk("sleeping", SLEEPING, m_sleep);
    chk("powerdn", RAM_POWERDN, m_sleep);
    chk("powerdn_disabled", z_pd, 0);
    if (ea || eb) begin
      c.we = ea ? a_we : b_we;
      c.addr = ea ? a_addr : b_addr;
      c.data = ea ? a_wdata : b_wdata;
      cq.push_back(c);
      if (c.we) mm[c.addr] = c.data;
      else begin
        r.who = eb;
        r.data = mm[c.addr];
        rq.push_back(r);
      end
      fav = ea ? 1 : 0;
    end
    if (run) begin
      m_idle = any ? 0 : m_idle + 1;
      if (IDLE > 0 && m_idle == IDLE) begin
        m_sleep = 1;
        m_idle = 0;
      end
    end else if (m_sleep) begin
      if (any) begin
        m_sleep = 0;
        m_wake = WAKE;
      end
    end else m_wake--;
    ga = ea;
    gb = eb;
  endtask
  task automatic tick(input int pa, input int pb);
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    #1;
    if (!a_req || ga) begin
      a_req = $urandom_range(0, 99) < pa;
      a_we = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom_range(0, 15));
      a_wdata = $urandom;
    end
    if (!b_req || gb) begin
      b_req = $urandom_range(0, 99) < pb;
      b_we = 1'($urandom_range(0, 1));
      b_addr = AW'($urandom_range(0, 15));
      b_wdata = $urandom;
    end
  endtask
  task automatic send(input bit who, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bit got = 0;
    if (who) begin
      b_req = 1; b_we = we; b_addr = ad; b_wdata = d;
    end else begin
      a_req = 1; a_we = we; a_addr = ad; a_wdata = d;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      tick(0, 0);
      got = who ? gb : ga;
    end
    chk("grant_wait", got, 1);
  endtask
  task automatic check_zero();
    chk("rst_ren", RAM_REN, 0);
    chk("rst_wen", RAM_WEN, 0);
    chk("rst_raddr", RAM_RADDR, 0);
    chk("rst_waddr", RAM_WADDR, 0);
    chk("rst_wdata", RAM_WDATA, 0);
    chk("rst_a_rvalid", A_RVALID, 0);
    chk("rst_b_rvalid", B_RVALID, 0);
    chk("rst_powerdn", RAM_POWERDN, 0);
    chk("rst_sleeping", SLEEPING, 0);
    chk("rmode", RAM_RMODE, ram_ctrl_pkg::MODE_X32);
    chk("wmode", RAM_WMODE, ram_ctrl_pkg::MODE_X32);
    chk("fmode_fflush_endian", {RAM_FMODE, RAM_FFLUSH, RAM_ENDIAN}, 0);
  endtask
  cmd_t mc;
  rd_t mr;
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (RAM_REN || RAM_WEN) begin
        chk("cmd_onehot", RAM_REN & RAM_WEN, 0);
        if (cq.size() == 0) chk("cmd_unexpected", cq.size(), 1);
        else begin
          mc = cq.pop_front();
          chk("cmd_we", RAM_WEN, mc.we);
          if (mc.we) begin
            chk("cmd_waddr", RAM_WADDR, mc.addr);
            chk("cmd_wdata", RAM_WDATA, mc.data);
          end else chk("cmd_raddr", RAM_RADDR, mc.addr);
        end
      end
      if (A_RVALID || B_RVALID) begin
        chk("rvalid_both", A_RVALID & B_RVALID, 0);
        if (rq.size() == 0) chk("rvalid_unexpected", rq.size(), 1);
        else begin
          mr = rq.pop_front();
          chk("rvalid_who", B_RVALID, mr.who);
          chk("rdata", mr.who ? B_RDATA : A_RDATA, mr.data);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = '0;
      mm[i] = '0;
    end
    repeat (2) @(negedge CLK);
    check_zero();
    RESET_N = 1;
    @(posedge CLK);
    #1;
    send(0, 1, 11'h005, 32'hDEADBEEF);
    send(0, 0, 11'h005, 32'h0);
    a_req = 1; a_we = 1'($urandom); a_addr = AW'($urandom_range(0, 15)); a_wdata = $urandom;
    b_req = 1; b_we = 1'($urandom); b_addr = AW'($urandom_range(0, 15)); b_wdata = $urandom;
    repeat (6) tick(100, 100);
    repeat (4) tick(0, 0);
    repeat (20) tick(0, 0);
    send(1, 0, 11'h005, 32'h0);
    repeat (15) tick(0, 0);
    send(1, 1, 11'h007, $urandom);
    repeat (300) tick(30, 30);
    repeat (10) tick(0, 0);
    repeat (110) tick(0, 0);
    send(0, 0, 11'h007, 32'h0);
    RESET_N = 0;
    a_req = 0;
    b_req = 0;
    cq.delete();
    rq.delete();
    fav = 0; m_idle = 0; m_wake = 0; m_sleep = 0; ga = 0; gb = 0;
    @(negedge CLK);
    check_zero();
    @(negedge CLK);
    RESET_N = 1;
    @(posedge CLK);
    #1;
    a_req = 1; a_we = 0; a_addr = 11'h005;
    b_req = 1; b_we = 0; b_addr = 11'h007;
    repeat (4) tick(0, 0);
    repeat (150) tick(40, 40);
    repeat (12) tick(0, 0);
    chk("cmd_queue_drained", cq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
